// File: rtl/ccff_chain_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states and CRC-16-CCITT constants.
package ccff_chain_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } loader_state_e;

    localparam int          CRC16_W    = 16;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_crc16_step.sv
// One-bit CRC-16-CCITT update, MSB-first, no reflection.
module ccff_crc16_step
    import ccff_chain_loader_pkg::*;
(
    input  logic [CRC16_W-1:0] crc_in,
    input  logic               bit_in,
    output logic [CRC16_W-1:0] crc_out
);

    logic feedback;

    // Shift left and fold in the polynomial when the outgoing MSB differs from the new bit
    assign feedback = crc_in[CRC16_W-1] ^ bit_in;
    assign crc_out  = {crc_in[CRC16_W-2:0], 1'b0} ^ (feedback ? CRC16_POLY : '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes host bitstream words MSB-first into the fabric configuration chain, drives the
// prog_clk gate enable, and optionally recirculates the chain once to compare CRCs.
module ccff_chain_loader
    import ccff_chain_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 6,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    output logic              verify_fail,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int               HCNT_W   = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);

    loader_state_e      state;
    logic [WORD_W-1:0]  hold_word;
    logic [HCNT_W-1:0]  hold_cnt;
    logic               head_q;
    logic               verify_mode;
    logic [CRC16_W-1:0] crc_load;
    logic [CRC16_W-1:0] crc_rb;
    logic [CRC16_W-1:0] crc_load_next;
    logic [CRC16_W-1:0] crc_rb_next;
    logic               last_shift;
    logic               take_word;
    logic               hold_shift;
    logic               start_accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == FULL_CNT) ? c : c + 1'b1;
    endfunction

    ccff_crc16_step u_crc_load (
        .crc_in  (crc_load),
        .bit_in  (head_q),
        .crc_out (crc_load_next)
    );

    ccff_crc16_step u_crc_rb (
        .crc_in  (crc_rb),
        .bit_in  (ccff_tail),
        .crc_out (crc_rb_next)
    );

    // The bit on the head this cycle is the final shift of the current phase
    assign last_shift   = chain_clk_en && (bit_count == LAST_IDX);
    // No new word is wanted once the final chain bit is already on the head
    assign cfg_ready    = (state == LOAD) && (hold_cnt == '0) && !last_shift;
    assign take_word    = cfg_valid && cfg_ready;
    assign hold_shift   = (state == LOAD) && !last_shift && (hold_cnt != '0);
    assign start_accept = start && ((state == IDLE) || (state == DONE));
    assign busy         = (state == LOAD) || (state == VERIFY);
    // During VERIFY the tail feeds the head directly so the recirculation loop is exactly
    // CHAIN_LEN flops long and CHAIN_LEN shifts leave the chain unchanged; head_q tracks it.
    assign ccff_head    = (state == VERIFY) ? ccff_tail : head_q;

    // FSM, holding-register occupancy, bit counter and registered chain controls
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state        <= IDLE;
            head_q       <= 1'b0;
            chain_clk_en <= 1'b0;
            hold_cnt     <= '0;
            bit_count    <= '0;
            verify_mode  <= 1'b0;
            done         <= 1'b0;
            verify_fail  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LOAD;
                        verify_mode  <= verify_en;
                        bit_count    <= '0;
                        hold_cnt     <= '0;
                        chain_clk_en <= 1'b0;
                        verify_fail  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (chain_clk_en) begin
                        bit_count <= sat_inc(bit_count);
                    end
                    if (last_shift) begin
                        hold_cnt     <= '0;
                        chain_clk_en <= verify_mode;
                        if (verify_mode) begin
                            state     <= VERIFY;
                            bit_count <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (hold_cnt != '0) begin
                        head_q       <= hold_word[WORD_W-1];
                        hold_cnt     <= hold_cnt - 1'b1;
                        chain_clk_en <= 1'b1;
                    end else if (take_word) begin
                        head_q       <= cfg_data[WORD_W-1];
                        hold_cnt     <= HCNT_W'(WORD_W - 1);
                        chain_clk_en <= 1'b1;
                    end else begin
                        chain_clk_en <= 1'b0;
                    end
                end
                VERIFY: begin
                    head_q    <= ccff_tail;
                    bit_count <= sat_inc(bit_count);
                    if (last_shift) begin
                        chain_clk_en <= 1'b0;
                        state        <= DONE;
                        done         <= 1'b1;
                        verify_fail  <= (crc_rb_next != crc_load);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word holding register and the two running CRCs
    always_ff @(posedge prog_clk) begin
        if (start_accept) begin
            crc_load <= CRC16_INIT;
            crc_rb   <= CRC16_INIT;
        end else begin
            if ((state == LOAD) && chain_clk_en) begin
                crc_load <= crc_load_next;
            end
            if (state == VERIFY) begin
                crc_rb <= crc_rb_next;
            end
        end
        if (hold_shift) begin
            hold_word <= hold_word << 1;
        end else if (take_word) begin
            hold_word <= cfg_data << 1;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 6-bit chain (3 stages x 2 bits) and a 20-bit chain model.
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    logic prog_reset = 1'b1;

    always #5 prog_clk = ~prog_clk;

    // 6-bit chain instance signals
    logic       start6 = 1'b0, ve6 = 1'b0, valid6 = 1'b0;
    logic [7:0] data6 = 8'h00;
    logic       ready6, head6, tail6, en6, busy6, done6, vf6;
    logic [2:0] cnt6;
    logic [5:0] chain6 = 6'd0;
    logic [5:0] stuck6 = 6'd0;
    int         edges6 = 0;

    // 20-bit chain instance signals
    logic        start20 = 1'b0, ve20 = 1'b0, valid20 = 1'b0;
    logic [7:0]  data20 = 8'h00;
    logic        ready20, head20, tail20, en20, busy20, done20, vf20;
    logic [4:0]  cnt20;
    logic [19:0] chain20 = 20'd0;
    int          edges20 = 0;

    int n_checks = 0;
    int n_errors = 0;

    ccff_chain_loader #(.CHAIN_LEN(6), .WORD_W(8)) dut6 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start6), .verify_en(ve6),
        .cfg_data(data6), .cfg_valid(valid6), .cfg_ready(ready6), .ccff_head(head6),
        .ccff_tail(tail6), .chain_clk_en(en6), .busy(busy6), .done(done6),
        .verify_fail(vf6), .bit_count(cnt6)
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start20), .verify_en(ve20),
        .cfg_data(data20), .cfg_valid(valid20), .cfg_ready(ready20), .ccff_head(head20),
        .ccff_tail(tail20), .chain_clk_en(en20), .busy(busy20), .done(done20),
        .verify_fail(vf20), .bit_count(cnt20)
    );

    // Behavioural chains: shift on enabled edges, stuck-at-0 mask on the 6-bit chain
    assign tail6  = chain6[5];
    assign tail20 = chain20[19];

    always @(posedge prog_clk) begin
        if (en6) begin
            chain6 <= {chain6[4:0], head6} & ~stuck6;
            edges6 <= edges6 + 1;
        end
        if (en20) begin
            chain20 <= {chain20[18:0], head20};
            edges20 <= edges20 + 1;
        end
    end

    typedef struct {
        logic       st, ve, va;
        logic [7:0] d;
        logic       rdy, hd, en, bz, dn;
        logic [2:0] cnt;
        logic       vf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(logic st, logic ve, logic va, logic [7:0] d, logic rdy,
                                 logic hd, logic en, logic bz, logic dn, logic [2:0] cnt,
                                 logic vf);
        vec_t v;
        v.st = st; v.ve = ve; v.va = va; v.d = d; v.rdy = rdy; v.hd = hd;
        v.en = en; v.bz = bz; v.dn = dn; v.cnt = cnt; v.vf = vf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_word6(input logic [7:0] w);
        int n = 0;
        while (ready6 !== 1'b1 && n < 40) begin
            @(negedge prog_clk);
            n++;
        end
        check("ready6 seen", 32'(ready6), 32'd1);
        valid6 = 1'b1;
        data6  = w;
        @(negedge prog_clk);
        valid6 = 1'b0;
    endtask

    task automatic send_word20(input logic [7:0] w);
        int n = 0;
        while (ready20 !== 1'b1 && n < 40) begin
            @(negedge prog_clk);
            n++;
        end
        check("ready20 seen", 32'(ready20), 32'd1);
        valid20 = 1'b1;
        data20  = w;
        @(negedge prog_clk);
        valid20 = 1'b0;
    endtask

    task automatic wait_done6();
        int n = 0;
        while (done6 !== 1'b1 && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        check("done6 seen", 32'(done6), 32'd1);
    endtask

    task automatic wait_done20();
        int n = 0;
        while (done20 !== 1'b1 && n < 100) begin
            @(negedge prog_clk);
            n++;
        end
        check("done20 seen", 32'(done20), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        //               st ve va data   rdy hd en bz dn cnt vf
        tbl.push_back(mkv(0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0)); // IDLE, stray valid
        tbl.push_back(mkv(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0)); // still IDLE, start
        tbl.push_back(mkv(0, 0, 1, 8'hB4, 1, 0, 0, 1, 0, 0, 0)); // LOAD, word offered
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mkv(1, 0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 0)); // start ignored
        tbl.push_back(mkv(1, 1, 0, 8'h00, 0, 1, 1, 1, 0, 2, 0)); // start+verify ignored
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 3, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 4, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 5, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 6, 0)); // done pulse
        tbl.push_back(mkv(1, 1, 0, 8'h00, 0, 1, 0, 0, 0, 6, 0)); // restart with verify
        tbl.push_back(mkv(0, 0, 1, 8'hB4, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 2, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 3, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 4, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 5, 0));
        tbl.push_back(mkv(1, 0, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0)); // VERIFY, start ignored
        tbl.push_back(mkv(0, 0, 1, 8'hFF, 0, 0, 1, 1, 0, 1, 0)); // valid ignored
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 2, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 3, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 4, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 5, 0));
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 6, 0)); // done, verify ok
        tbl.push_back(mkv(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 6, 0));

        repeat (3) @(negedge prog_clk);
        prog_reset = 1'b0;

        // Cycle-by-cycle load without verify, then load with verify
        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("row%0d cfg_ready", i),   32'(ready6), 32'(tbl[i].rdy));
            check($sformatf("row%0d ccff_head", i),   32'(head6),  32'(tbl[i].hd));
            check($sformatf("row%0d clk_en", i),      32'(en6),    32'(tbl[i].en));
            check($sformatf("row%0d busy", i),        32'(busy6),  32'(tbl[i].bz));
            check($sformatf("row%0d done", i),        32'(done6),  32'(tbl[i].dn));
            check($sformatf("row%0d bit_count", i),   32'(cnt6),   32'(tbl[i].cnt));
            check($sformatf("row%0d verify_fail", i), 32'(vf6),    32'(tbl[i].vf));
            start6 = tbl[i].st;
            ve6    = tbl[i].ve;
            valid6 = tbl[i].va;
            data6  = tbl[i].d;
            @(negedge prog_clk);
        end
        start6 = 1'b0; ve6 = 1'b0; valid6 = 1'b0;
        check("chain6 after verify", 32'(chain6), 32'h2D);
        check("edges6 after two loads+verify", 32'(edges6), 32'd18);

        // Stuck-at-0 on stage 1 must be caught by the CRC compare
        stuck6 = 6'b001100;
        start6 = 1'b1; ve6 = 1'b1;
        @(negedge prog_clk);
        start6 = 1'b0; ve6 = 1'b0;
        send_word6(8'hB4);
        wait_done6();
        check("stuck verify_fail", 32'(vf6), 32'd1);
        @(negedge prog_clk);
        check("verify_fail sticky", 32'(vf6), 32'd1);
        check("done single pulse", 32'(done6), 32'd0);
        stuck6 = 6'b000000;

        // Reset in the middle of a load
        start6 = 1'b1;
        @(negedge prog_clk);
        start6 = 1'b0;
        send_word6(8'hB4);
        n = 0;
        while (cnt6 !== 3'd3 && n < 20) begin
            @(negedge prog_clk);
            n++;
        end
        check("reached bit 3", 32'(cnt6), 32'd3);
        prog_reset = 1'b1;
        @(negedge prog_clk);
        prog_reset = 1'b0;
        check("rst cfg_ready", 32'(ready6), 32'd0);
        check("rst ccff_head", 32'(head6),  32'd0);
        check("rst clk_en",    32'(en6),    32'd0);
        check("rst busy",      32'(busy6),  32'd0);
        check("rst done",      32'(done6),  32'd0);
        check("rst vfail",     32'(vf6),    32'd0);
        check("rst bit_count", 32'(cnt6),   32'd0);
        base = edges6;
        start6 = 1'b1;
        @(negedge prog_clk);
        start6 = 1'b0;
        send_word6(8'h5C);
        wait_done6();
        check("reload chain6", 32'(chain6), 32'h17);
        check("reload edges6", 32'(edges6 - base), 32'd6);
        check("reload vfail",  32'(vf6), 32'd0);

        // 20-bit chain with a 5-cycle host gap after the first word
        start20 = 1'b1;
        @(negedge prog_clk);
        start20 = 1'b0;
        base = edges20;
        send_word20(8'hA5);
        repeat (7) @(negedge prog_clk);
        check("w1 last bit ready", 32'(ready20), 32'd1);
        @(negedge prog_clk);
        for (int g = 0; g < 5; g++) begin
            check($sformatf("gap%0d clk_en", g), 32'(en20),   32'd0);
            check($sformatf("gap%0d count", g),  32'(cnt20),  32'd8);
            check($sformatf("gap%0d head", g),   32'(head20), 32'd1);
            @(negedge prog_clk);
        end
        send_word20(8'h3C);
        repeat (7) @(negedge prog_clk);
        check("w2 last bit ready", 32'(ready20), 32'd1);
        valid20 = 1'b1;
        data20  = 8'hF9;
        @(negedge prog_clk);
        valid20 = 1'b0;
        check("w3 back-to-back en", 32'(en20),   32'd1);
        check("w3 first count",     32'(cnt20),  32'd16);
        check("w3 first head",      32'(head20), 32'd1);
        wait_done20();
        check("chain20 contents", 32'(chain20), 32'hA53CF);
        check("edges20 total",    32'(edges20 - base), 32'd20);
        check("count20 final",    32'(cnt20), 32'd20);
        check("busy20 at done",   32'(busy20), 32'd0);
        check("vfail20 no verify", 32'(vf20), 32'd0);
        check("ready20 after load", 32'(ready20), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
